// File: rtl/my_logic_pipe.sv
// Pipelined bitwise logic unit: 8 ops on WIDTH-bit operands, optional accumulator feedback, STAGES-cycle latency.
// Valid/ready per stage; in_ready falls only when every stage is full and out_ready is low.
module my_logic_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             neg,
  output logic [WIDTH-1:0] acc
);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             neg;
  } stage_t;

  stage_t            stg_dat [STAGES];
  logic [STAGES-1:0] stg_vld;
  logic [STAGES-1:0] stg_rdy;
  logic [WIDTH-1:0]  acc_q;
  logic [WIDTH-1:0]  opa;
  logic [WIDTH-1:0]  res;
  logic              accept;

  always_comb begin
    opa = acc_mode ? acc_q : a;
    case (op)
      3'b000:  res = opa & b;
      3'b001:  res = opa | b;
      3'b010:  res = opa ^ b;
      3'b011:  res = ~(opa & b);
      3'b100:  res = ~(opa | b);
      3'b101:  res = ~(opa ^ b);
      3'b110:  res = ~opa;
      default: res = opa & ~b;
    endcase
  end

  // A stage can load when it is empty or its content moves on this cycle; ripples back from out_ready.
  always_comb begin
    logic r;
    stg_rdy = '0;
    r = !stg_vld[STAGES-1] || out_ready;
    stg_rdy[STAGES-1] = r;
    for (int k = STAGES - 2; k >= 0; k--) begin
      r = !stg_vld[k] || r;
      stg_rdy[k] = r;
    end
  end

  assign in_ready = stg_rdy[0];
  assign accept   = in_valid && stg_rdy[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld <= '0;
      acc_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        stg_dat[k].res  <= '0;
        stg_dat[k].zero <= 1'b1;
        stg_dat[k].neg  <= 1'b0;
      end
    end else begin
      if (stg_rdy[0]) stg_vld[0] <= in_valid;
      if (accept) begin
        stg_dat[0].res  <= res;
        stg_dat[0].zero <= (res == '0);
        stg_dat[0].neg  <= res[WIDTH-1];
      end
      for (int k = 1; k < STAGES; k++) begin
        if (stg_rdy[k]) begin
          stg_vld[k] <= stg_vld[k-1];
          if (stg_vld[k-1]) stg_dat[k] <= stg_dat[k-1];
        end
      end
      // Clear wins over an update, but the accepted op already used the old value.
      if (acc_clr)     acc_q <= '0;
      else if (accept) acc_q <= res;
    end
  end

  assign out_valid = stg_vld[STAGES-1];
  assign out       = stg_dat[STAGES-1].res;
  assign zero      = stg_dat[STAGES-1].zero;
  assign neg       = stg_dat[STAGES-1].neg;
  assign acc       = acc_q;

endmodule

// File: tb/tb_my_logic_pipe.sv
// Directed bench for my_logic_pipe: default instance plus WIDTH=8/STAGES=1 and WIDTH=32/STAGES=4 instances.
module tb_my_logic_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, acc_mode, acc_clr, out_valid, out_ready, zero, neg;
  logic [2:0]  op;
  logic [15:0] a, b, out, acc;

  logic        p1_in_valid, p1_in_ready, p1_out_valid, p1_zero, p1_neg;
  logic [7:0]  p1_a, p1_b, p1_out, p1_acc;
  logic        p4_in_valid, p4_in_ready, p4_out_valid, p4_zero, p4_neg;
  logic [31:0] p4_a, p4_b, p4_out, p4_acc;

  always #5 clk = ~clk;

  my_logic_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .acc_mode(acc_mode), .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zero(zero), .neg(neg), .acc(acc));

  my_logic_pipe #(.WIDTH(8), .STAGES(1)) dut_p1 (
    .clk(clk), .rst_n(rst_n), .in_valid(p1_in_valid), .in_ready(p1_in_ready), .op(op), .a(p1_a), .b(p1_b),
    .acc_mode(1'b0), .acc_clr(1'b0), .out_valid(p1_out_valid), .out_ready(out_ready),
    .out(p1_out), .zero(p1_zero), .neg(p1_neg), .acc(p1_acc));

  my_logic_pipe #(.WIDTH(32), .STAGES(4)) dut_p4 (
    .clk(clk), .rst_n(rst_n), .in_valid(p4_in_valid), .in_ready(p4_in_ready), .op(op), .a(p4_a), .b(p4_b),
    .acc_mode(1'b0), .acc_clr(1'b0), .out_valid(p4_out_valid), .out_ready(out_ready),
    .out(p4_out), .zero(p4_zero), .neg(p4_neg), .acc(p4_acc));

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
    logic        ez;
    logic        en;
  } vec_t;

  vec_t        vt [11];
  logic [15:0] got [$];
  int          checks = 0;
  int          passed = 0;

  // Results handed to the consumer on the following rising edge.
  always @(negedge clk) if (rst_n && out_valid && out_ready) got.push_back(out);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_got(input int n);
    int g = 0;
    while (got.size() < n && g < 30) begin
      @(posedge clk); #1; g++;
    end
    chk("drain_count", 64'(got.size()), 64'(n));
  endtask

  initial begin
    int lat, lat1, lat4, n, r1, r4, v1, v4;
    vt[0]  = '{3'b000, 16'hE000, 16'hA000, 16'hA000, 1'b0, 1'b1};
    vt[1]  = '{3'b000, 16'h000C, 16'h0004, 16'h0004, 1'b0, 1'b0};
    vt[2]  = '{3'b000, 16'h00FF, 16'h0F0F, 16'h000F, 1'b0, 1'b0};
    vt[3]  = '{3'b001, 16'h00FF, 16'h0F0F, 16'h0FFF, 1'b0, 1'b0};
    vt[4]  = '{3'b010, 16'h00FF, 16'h0F0F, 16'h0FF0, 1'b0, 1'b0};
    vt[5]  = '{3'b011, 16'h00FF, 16'h0F0F, 16'hFFF0, 1'b0, 1'b1};
    vt[6]  = '{3'b100, 16'h00FF, 16'h0F0F, 16'hF000, 1'b0, 1'b1};
    vt[7]  = '{3'b101, 16'h00FF, 16'h0F0F, 16'hF00F, 1'b0, 1'b1};
    vt[8]  = '{3'b110, 16'h00FF, 16'h0F0F, 16'hFF00, 1'b0, 1'b1};
    vt[9]  = '{3'b111, 16'h00FF, 16'h0F0F, 16'h00F0, 1'b0, 1'b0};
    vt[10] = '{3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};

    in_valid = 0; acc_mode = 0; acc_clr = 0; out_ready = 1; op = 0; a = 0; b = 0;
    p1_in_valid = 0; p1_a = 0; p1_b = 0; p4_in_valid = 0; p4_a = 0; p4_b = 0;
    rst_n = 1;
    #1 rst_n = 0;
    #11;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_zero", zero, 1);
    chk("rst_neg", neg, 0);
    chk("rst_acc", acc, 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    // Single transactions: latency in edges counted from the accepting edge.
    for (int i = 0; i < 11; i++) begin
      op = vt[i].op; a = vt[i].a; b = vt[i].b; in_valid = 1;
      lat = 0;
      do begin
        @(posedge clk); #1; in_valid = 0; lat++;
      end while (!out_valid && lat < 10);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 2);
      chk($sformatf("vec%0d_out", i), out, vt[i].exp);
      chk($sformatf("vec%0d_zero", i), zero, vt[i].ez);
      chk($sformatf("vec%0d_neg", i), neg, vt[i].en);
    end

    // Accumulate chain at full rate; operand a must be ignored.
    acc_clr = 1; @(posedge clk); #1; acc_clr = 0;
    chk("acc_cleared", acc, 0);
    got.delete();
    op = 3'b001; acc_mode = 1; a = 16'hFFFF;
    for (int j = 0; j < 3; j++) begin
      b = 16'h0001 << j; in_valid = 1;
      @(posedge clk); #1;
    end
    in_valid = 0;
    chk("acc_chain_acc", acc, 16'h0007);
    wait_got(3);
    chk("acc_chain_0", got[0], 16'h0001);
    chk("acc_chain_1", got[1], 16'h0003);
    chk("acc_chain_2", got[2], 16'h0007);

    got.delete();
    op = 3'b010; b = 16'h0001; acc_clr = 1; in_valid = 1;
    @(posedge clk); #1; in_valid = 0; acc_clr = 0; acc_mode = 0;
    chk("clr_same_cycle_acc", acc, 0);
    wait_got(1);
    chk("clr_same_cycle_out", got[0], 16'h0006);

    // Back-pressure: out_ready low for 5 cycles while streaming 6 transactions.
    got.delete();
    op = 3'b001; out_ready = 0; n = 0;
    for (int c = 0; c < 5; c++) begin
      a = 16'(n); b = 16'h0100 << n; in_valid = 1;
      if (in_ready) n++;
      @(posedge clk); #1;
    end
    chk("bp_accepts", 64'(n), 2);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_out_held", out, 16'h0100);
    out_ready = 1; #1;
    chk("bp_push_pop_ready", in_ready, 1);
    lat = 0;
    while (n < 6 && lat < 20) begin
      a = 16'(n); b = 16'h0100 << n; in_valid = 1;
      if (in_ready) n++;
      @(posedge clk); #1; lat++;
    end
    in_valid = 0;
    wait_got(6);
    for (int k = 0; k < 6; k++)
      chk($sformatf("bp_order%0d", k), got[k], 16'(k) + (16'h0100 << k));

    // Reset with two transactions in flight.
    out_ready = 0; op = 3'b000; a = 16'hFFFF; b = 16'h1234; in_valid = 1;
    @(posedge clk); #1; b = 16'h00F0;
    @(posedge clk); #1; in_valid = 0;
    chk("midrst_inflight", out_valid, 1);
    #2 rst_n = 0; #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_acc", acc, 0);
    chk("midrst_zero", zero, 1);
    chk("midrst_out", out, 0);
    @(negedge clk); rst_n = 1; got.delete(); out_ready = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_stale", 64'(got.size()), 0);
    chk("midrst_out_valid_after", out_valid, 0);

    // Parameter variants: latency and sign bit.
    op = 3'b110; p1_a = 8'h7F; p1_b = 8'h00; p4_a = 32'h7FFF_FFFF; p4_b = 0;
    p1_in_valid = 1; p4_in_valid = 1; lat1 = 0; lat4 = 0;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); #1; p1_in_valid = 0; p4_in_valid = 0;
      if (p1_out_valid && lat1 == 0) begin
        lat1 = e;
        chk("p1_out", p1_out, 8'h80);
        chk("p1_neg", p1_neg, 1);
      end
      if (p4_out_valid && lat4 == 0) begin
        lat4 = e;
        chk("p4_out", p4_out, 32'h8000_0000);
        chk("p4_neg", p4_neg, 1);
      end
    end
    chk("p1_latency", 64'(lat1), 1);
    chk("p4_latency", 64'(lat4), 4);

    // Parameter variants: full throughput over a 4-deep burst.
    r1 = 0; r4 = 0; v1 = 0; v4 = 0;
    for (int e = 1; e <= 8; e++) begin
      p1_in_valid = (e <= 4); p4_in_valid = (e <= 4);
      p1_a = 8'(e); p4_a = (e == 4) ? 32'hFFFF_FFFF : 32'(e);
      if (e <= 4 && p1_in_ready) r1++;
      if (e <= 4 && p4_in_ready) r4++;
      @(posedge clk); #1;
      if (p1_out_valid) v1++;
      if (p4_out_valid) v4++;
      if (e == 7) chk("p4_zero_last", p4_zero, 1);
    end
    p1_in_valid = 0; p4_in_valid = 0;
    chk("p1_ready_burst", 64'(r1), 4);
    chk("p4_ready_burst", 64'(r4), 4);
    chk("p1_valid_burst", 64'(v1), 4);
    chk("p4_valid_burst", 64'(v4), 4);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
